wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parametrised multi-source writeback stage for the core pipeline. Collects results from NUM_SRC independent producers (e.g. ALU pipe, variable-latency LSU, CSR unit), buffers each in a small per-source FIFO, and arbitrates them onto the single register-file write port. It also publishes a pending-destination bitmap for hazard detection. The block replaces the fixed single-result writeback path and sits between the producer stages and the register file.

## Interface
Parameters:
- NUM_SRC, 3: number of producer channels (≥2)
- FIFO_DEPTH, 2: entries per source FIFO (≥1; power of two not required)
- XLEN, 32: data width
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (source 0 highest)

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous, active-low reset
- src_valid_i  in  NUM_SRC  per-source request valid
- src_ready_o  out  NUM_SRC  per-source FIFO can accept
- src_rd_i  in  NUM_SRC*5  destination register, source s at [5s+4:5s]
- src_data_i  in  NUM_SRC*XLEN  result data, source s at [XLEN*s +: XLEN]
- src_rf_en_i  in  NUM_SRC  1 = write RF; 0 = retire without write
- flush_i  in  1  synchronous discard of all buffered results
- wb_valid_o  out  1  writeback slot occupied this cycle
- wb_rf_en_o  out  1  RF write enable
- wb_rd_o  out  5  RF write address
- wb_data_o  out  XLEN  RF write data
- wb_src_o  out  $clog2(NUM_SRC)  index of granted source
- pending_o  out  32  bit r = buffered write to x r outstanding

## Operation
- Push: source s accepted when src_valid_i[s] & src_ready_o[s]; {rd, data, rf_en} written at FIFO tail.
- src_ready_o[s] = (count_s < FIFO_DEPTH) & ~flush_i; independent of src_valid_i and of a same-cycle pop (no full pass-through).
- Arbitration every cycle among non-empty FIFO heads; at most one grant; winner's head popped.
- Round-robin: search starts at rr_q, ascending modulo NUM_SRC; on grant g, rr_q <= (g+1) mod NUM_SRC; no grant leaves rr_q unchanged.
- Fixed: lowest-index non-empty source wins; rr_q unused.
- Output register loaded every cycle: wb_valid_o <= grant; payload from winner; wb_rf_en_o <= grant & rf_en & (rd != 0). rd = 0 entries retire with wb_valid_o = 1, wb_rf_en_o = 0.
- Ordering: strict FIFO order within a source; no ordering across sources.
- pending_o[r] = 1 iff any valid FIFO entry has rf_en = 1 and rd = r, r ≠ 0; pending_o[0] always 0. Combinational from FIFO state; excludes the output register.
- Flush: all FIFO counts and pointers cleared at the edge; wb_valid_o <= 0; no grant in the flush cycle; rr_q kept.

## Timing
- Reset (arst_n low, asynchronous): all FIFOs empty, rr_q = 0, wb_valid_o = 0, wb_rf_en_o = 0, wb_rd_o = 0, wb_data_o = 0, wb_src_o = 0; pending_o = 0 and src_ready_o all 1 once released (flush_i low). Reset mid-operation discards all buffered entries.
- Latency: accepted at edge k -> head valid after k -> granted in cycle k+1 -> wb_*_o valid in the cycle after edge k+1 (2 edges minimum).
- Throughput: one writeback per cycle aggregate, FIFO_DEPTH per source before backpressure.
- FIFO pointers wrap FIFO_DEPTH-1 -> 0; count width $clog2(FIFO_DEPTH+1).
- Simultaneous push and pop on a non-full FIFO: count unchanged, both take effect.
- The output register never stalls; the RF always accepts.

## Structure
- wb_stage_pkg gains wb_req_t {rd[4:0], data[XLEN-1:0], rf_en} and PRIO_RR/PRIO_FIXED constants.
- Sub-module wb_fifo: single-source FIFO (push/pop/flush, count, head, full/empty, per-entry visibility for pending_o), instantiated NUM_SRC times.
- Arbiter, rr_q, output register and pending_o reduction live in wb_arbiter.

## Test plan
- RR, NUM_SRC=3: all sources push at cycle 0 (rd 1/2/3, data 0xA/0xB/0xC) -> wb_src_o 0,1,2 in cycles 2,3,4; rd/data match; rr_q ends at 0.
- Fixed priority: source 0 streams every cycle, source 1 pushes rd=5 -> source 1 starved; src_ready_o[1] low after 2 accepted entries; pending_o[5]=1 until source 0 stops, then source 1 drains in order.
- rd=0 with rf_en=1 from source 2 -> wb_valid_o=1, wb_rf_en_o=0, pending_o stays 0.
- src_rf_en_i=0, rd=7 -> retires with wb_rf_en_o=0, pending_o[7] never set.
- flush_i asserted with 4 entries buffered -> next cycle pending_o=0, wb_valid_o=0, src_ready_o all 1; flush-cycle pushes dropped.
- arst_n pulsed low mid-stream -> outputs immediately at reset values, no buffered entry written back after release.

Source files
------------

// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_pkg
// Purpose  : Shared types and constants for the multi-source writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam int c_RD_W    = 5;
    localparam int c_TAG_W   = c_RD_W + 1;
    localparam int c_WB_XLEN = 32;

    typedef struct packed {
        logic [c_RD_W-1:0]    rd;
        logic [c_WB_XLEN-1:0] data;
        logic                 rf_en;
    } wb_req_t;

    // Flat FIFO entry layout is {data, rd, rf_en}; the low c_TAG_W bits are the hazard tag.
    function automatic int req_width(input int xlen);
        return xlen + c_TAG_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Single-producer result FIFO with flush and per-entry tag visibility.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38,
    parameter int TAG_W = 6
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_push_data,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic [DEPTH-1:0]             o_entry_valid,
    output logic [DEPTH*TAG_W-1:0]       o_tags
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_W'(DEPTH-1)) ? '0 : ptr + 1'b1;
    endfunction

    assign w_push  = i_push & (r_count != c_CNT_W'(DEPTH));
    assign w_pop   = i_pop  & (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        int w_off;
        w_off         = 0;
        o_entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = i - int'(r_rd_ptr);
            if (w_off < 0) w_off = w_off + DEPTH;
            o_entry_valid[i] = (w_off < int'(r_count));
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_tags
            assign o_tags[i*TAG_W +: TAG_W] = r_mem[i][TAG_W-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Buffers NUM_SRC producer results and arbitrates them onto the
//            single register-file write port; publishes pending destinations.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_stage_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32,
    parameter int PRIO_MODE  = 0
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [NUM_SRC-1:0]          src_valid_i,
    output logic [NUM_SRC-1:0]          src_ready_o,
    input  logic [NUM_SRC*5-1:0]        src_rd_i,
    input  logic [NUM_SRC*XLEN-1:0]     src_data_i,
    input  logic [NUM_SRC-1:0]          src_rf_en_i,
    input  logic                        flush_i,
    output logic                        wb_valid_o,
    output logic                        wb_rf_en_o,
    output logic [4:0]                  wb_rd_o,
    output logic [XLEN-1:0]             wb_data_o,
    output logic [$clog2(NUM_SRC)-1:0]  wb_src_o,
    output logic [31:0]                 pending_o
);

    localparam int c_SRC_W = $clog2(NUM_SRC);
    localparam int c_REQ_W = req_width(XLEN);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH+1);

    logic [c_REQ_W-1:0]            w_push_data [NUM_SRC];
    logic [c_REQ_W-1:0]            w_head      [NUM_SRC];
    logic [c_CNT_W-1:0]            w_count     [NUM_SRC];
    logic [FIFO_DEPTH-1:0]         w_vis       [NUM_SRC];
    logic [FIFO_DEPTH*c_TAG_W-1:0] w_tags      [NUM_SRC];
    logic [NUM_SRC-1:0]            w_push;
    logic [NUM_SRC-1:0]            w_pop;
    logic [NUM_SRC-1:0]            w_empty;
    logic                          w_grant;
    logic [c_SRC_W-1:0]            w_grant_idx;
    logic [c_REQ_W-1:0]            w_sel;
    logic [31:0]                   w_pending;

    logic [c_SRC_W-1:0]            r_rr;
    logic                          r_wb_valid;
    logic                          r_wb_rf_en;
    logic [4:0]                    r_wb_rd;
    logic [XLEN-1:0]               r_wb_data;
    logic [c_SRC_W-1:0]            r_wb_src;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            assign w_push_data[s] = {src_data_i[XLEN*s +: XLEN], src_rd_i[5*s +: 5], src_rf_en_i[s]};
            // Readiness looks only at stored occupancy, never at a same-cycle pop.
            assign src_ready_o[s] = (w_count[s] < c_CNT_W'(FIFO_DEPTH)) & ~flush_i;
            assign w_push[s]      = src_valid_i[s] & src_ready_o[s];

            wb_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (c_REQ_W),
                .TAG_W (c_TAG_W)
            ) u_fifo (
                .clk           (clk),
                .arst_n        (arst_n),
                .i_push        (w_push[s]),
                .i_pop         (w_pop[s]),
                .i_flush       (flush_i),
                .i_push_data   (w_push_data[s]),
                .o_head        (w_head[s]),
                .o_count       (w_count[s]),
                .o_empty       (w_empty[s]),
                .o_entry_valid (w_vis[s]),
                .o_tags        (w_tags[s])
            );
        end
    endgenerate

    always_comb begin
        int w_idx;
        w_idx       = 0;
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_pop       = '0;
        if (!flush_i) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (PRIO_MODE == PRIO_FIXED) begin
                    w_idx = k;
                end else begin
                    w_idx = int'(r_rr) + k;
                    if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
                end
                if (!w_grant && !w_empty[w_idx]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = c_SRC_W'(w_idx);
                end
            end
        end
        if (w_grant) w_pop[w_grant_idx] = 1'b1;
    end

    always_comb begin
        w_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_pop[s]) w_sel = w_head[s];
        end
    end

    // Hazard bitmap covers buffered entries only; x0 writes never count.
    always_comb begin
        w_pending = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (w_vis[s][e] && w_tags[s][e*c_TAG_W] &&
                    (w_tags[s][e*c_TAG_W+1 +: c_RD_W] != '0)) begin
                    w_pending[w_tags[s][e*c_TAG_W+1 +: c_RD_W]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rr <= '0;
        end else if (w_grant) begin
            r_rr <= (w_grant_idx == c_SRC_W'(NUM_SRC-1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rf_en <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_src   <= '0;
        end else begin
            r_wb_valid <= w_grant;
            r_wb_rf_en <= w_grant & w_sel[0] & (w_sel[c_TAG_W-1:1] != '0);
            if (w_grant) begin
                r_wb_rd   <= w_sel[c_TAG_W-1:1];
                r_wb_data <= w_sel[c_REQ_W-1:c_TAG_W];
                r_wb_src  <= w_grant_idx;
            end
        end
    end

    assign wb_valid_o = r_wb_valid;
    assign wb_rf_en_o = r_wb_rf_en;
    assign wb_rd_o    = r_wb_rd;
    assign wb_data_o  = r_wb_data;
    assign wb_src_o   = r_wb_src;
    assign pending_o  = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench; round-robin and fixed-priority instances
//            share stimulus and are compared against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int N = 3;
    localparam int D = 2;
    localparam int X = 32;

    logic           clk = 1'b0;
    logic           arst_n;
    logic [N-1:0]   src_valid;
    logic [N*5-1:0] src_rd;
    logic [N*X-1:0] src_data;
    logic [N-1:0]   src_rf_en;
    logic           flush;

    logic [N-1:0]   ready    [2];
    logic           wb_valid [2];
    logic           wb_rf_en [2];
    logic [4:0]     wb_rd    [2];
    logic [X-1:0]   wb_data  [2];
    logic [1:0]     wb_src   [2];
    logic [31:0]    pend     [2];

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .XLEN(X), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .arst_n(arst_n), .src_valid_i(src_valid), .src_ready_o(ready[0]),
        .src_rd_i(src_rd), .src_data_i(src_data), .src_rf_en_i(src_rf_en), .flush_i(flush),
        .wb_valid_o(wb_valid[0]), .wb_rf_en_o(wb_rf_en[0]), .wb_rd_o(wb_rd[0]),
        .wb_data_o(wb_data[0]), .wb_src_o(wb_src[0]), .pending_o(pend[0])
    );

    wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .XLEN(X), .PRIO_MODE(1)) dut_fx (
        .clk(clk), .arst_n(arst_n), .src_valid_i(src_valid), .src_ready_o(ready[1]),
        .src_rd_i(src_rd), .src_data_i(src_data), .src_rf_en_i(src_rf_en), .flush_i(flush),
        .wb_valid_o(wb_valid[1]), .wb_rf_en_o(wb_rf_en[1]), .wb_rd_o(wb_rd[1]),
        .wb_data_o(wb_data[1]), .wb_src_o(wb_src[1]), .pending_o(pend[1])
    );

    // Reference model: one queue per (mode, source); mode 0 = round-robin, 1 = fixed.
    typedef struct {
        logic [4:0]   rd;
        logic [X-1:0] data;
        logic         rf_en;
    } req_t;

    req_t         mq [2*N][$];
    int           m_rr;
    logic         e_valid [2];
    logic         e_rf_en [2];
    logic [4:0]   e_rd    [2];
    logic [X-1:0] e_data  [2];
    int           e_src   [2];
    logic [N-1:0] e_ready [2];
    logic [N-1:0] o_ready [2];
    logic [31:0]  e_pend  [2];
    logic [31:0]  o_pend  [2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic model_reset();
        for (int q = 0; q < 2*N; q++) mq[q].delete();
        m_rr = 0;
        for (int m = 0; m < 2; m++) begin
            e_valid[m] = 1'b0;
            e_rf_en[m] = 1'b0;
            e_rd[m]    = '0;
            e_data[m]  = '0;
            e_src[m]   = 0;
        end
    endtask

    task automatic drive(input int s, input logic v, input logic [4:0] rd,
                         input logic [X-1:0] d, input logic rfen);
        src_valid[s]        = v;
        src_rd[5*s +: 5]    = rd;
        src_data[X*s +: X]  = d;
        src_rf_en[s]        = rfen;
    endtask

    task automatic idle();
        src_valid = '0;
        flush     = 1'b0;
    endtask

    // One clock: snapshot combinational outputs before the edge, step the model,
    // then return #1 after the edge with registered expectations updated.
    task automatic advance();
        int   win;
        int   q;
        int   s;
        req_t r;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            e_pend[m] = '0;
            for (int si = 0; si < N; si++) begin
                q = m*N + si;
                e_ready[m][si] = (mq[q].size() < D) && !flush;
                for (int i = 0; i < mq[q].size(); i++) begin
                    if (mq[q][i].rf_en && mq[q][i].rd != 5'd0) e_pend[m][mq[q][i].rd] = 1'b1;
                end
            end
            o_ready[m] = ready[m];
            o_pend[m]  = pend[m];
        end
        for (int m = 0; m < 2; m++) begin
            win = -1;
            if (!flush) begin
                for (int k = 0; k < N; k++) begin
                    s = (m == 0) ? (m_rr + k) % N : k;
                    if (win < 0 && mq[m*N + s].size() != 0) win = s;
                end
            end
            if (win >= 0) begin
                r          = mq[m*N + win].pop_front();
                e_valid[m] = 1'b1;
                e_rf_en[m] = r.rf_en && (r.rd != 5'd0);
                e_rd[m]    = r.rd;
                e_data[m]  = r.data;
                e_src[m]   = win;
                if (m == 0) m_rr = (win + 1) % N;
            end else begin
                e_valid[m] = 1'b0;
                e_rf_en[m] = 1'b0;
            end
            for (int si = 0; si < N; si++) begin
                if (flush) begin
                    mq[m*N + si].delete();
                end else if (src_valid[si] && e_ready[m][si]) begin
                    r.rd    = src_rd[5*si +: 5];
                    r.data  = src_data[X*si +: X];
                    r.rf_en = src_rf_en[si];
                    mq[m*N + si].push_back(r);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if ({wb_valid[m], wb_rf_en[m], wb_rd[m], wb_data[m], wb_src[m]} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: got v=%b en=%b rd=%0d data=%h src=%0d, want all 0",
                         m, wb_valid[m], wb_rf_en[m], wb_rd[m], wb_data[m], wb_src[m]);
            end
        end
        @(negedge clk);
        #2 arst_n = 1'b1;
        @(posedge clk);
        #1;
        advance();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_ready[m] !== 3'b111 || o_pend[m] !== 32'd0 || wb_valid[m] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release dut%0d: got ready=%b pend=%h v=%b, want 111/0/0",
                         m, o_ready[m], o_pend[m], wb_valid[m]);
            end
        end
    endtask

    task automatic test_rr_order();
        drive(0, 1'b1, 5'd1, 32'hA, 1'b1);
        drive(1, 1'b1, 5'd2, 32'hB, 1'b1);
        drive(2, 1'b1, 5'd3, 32'hC, 1'b1);
        advance();
        idle();
        for (int c = 0; c < 3; c++) begin
            advance();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (wb_valid[m] !== 1'b1 || wb_src[m] !== 2'(c) || wb_rd[m] !== 5'(c+1) ||
                    wb_data[m] !== 32'hA + 32'(c) || wb_rf_en[m] !== 1'b1) begin
                    n_err++;
                    $display("FAIL rr_order dut%0d slot%0d: got v=%b src=%0d rd=%0d data=%h, want 1/%0d/%0d/%h",
                             m, c, wb_valid[m], wb_src[m], wb_rd[m], wb_data[m], c, c+1, 32'hA + 32'(c));
                end
            end
        end
        // Pointer must be back at 0: source 0 wins a simultaneous 0/1 request.
        drive(0, 1'b1, 5'd4, 32'h40, 1'b1);
        drive(1, 1'b1, 5'd6, 32'h60, 1'b1);
        advance();
        idle();
        for (int c = 0; c < 2; c++) begin
            advance();
            n_cmp++;
            if (wb_valid[0] !== 1'b1 || wb_src[0] !== 2'(c)) begin
                n_err++;
                $display("FAIL rr_wrap slot%0d: got v=%b src=%0d, want 1/%0d", c, wb_valid[0], wb_src[0], c);
            end
        end
        advance();
    endtask

    task automatic test_fixed_starve();
        logic [X-1:0] got [$];
        for (int c = 0; c < 8; c++) begin
            drive(0, 1'b1, 5'(10 + c), $urandom, 1'b1);
            drive(1, 1'b1, 5'd5, 32'h100 + 32'(c), 1'b1);
            advance();
            if (c >= 3) begin
                n_cmp++;
                if (o_ready[1][1] !== 1'b0 || o_pend[1][5] !== 1'b1) begin
                    n_err++;
                    $display("FAIL starve_hold c%0d: got ready1=%b pend5=%b, want 0/1", c, o_ready[1][1], o_pend[1][5]);
                end
                n_cmp++;
                if (wb_valid[1] !== 1'b1 || wb_src[1] !== 2'd0) begin
                    n_err++;
                    $display("FAIL starve_grant c%0d: got v=%b src=%0d, want 1/0", c, wb_valid[1], wb_src[1]);
                end
            end
        end
        idle();
        for (int c = 0; c < 6; c++) begin
            advance();
            if (wb_valid[1] === 1'b1 && wb_src[1] === 2'd1) got.push_back(wb_data[1]);
        end
        n_cmp++;
        if (got.size() != 2) begin
            n_err++;
            $display("FAIL starve_drain_count: got %0d entries, want 2", got.size());
        end else if (got[0] !== 32'h100 || got[1] !== 32'h101) begin
            n_err++;
            $display("FAIL starve_drain_order: got %h,%h want 100,101", got[0], got[1]);
        end
        n_cmp++;
        if (o_pend[1] !== 32'd0) begin
            n_err++;
            $display("FAIL starve_pend_clear: got %h, want 0", o_pend[1]);
        end
    endtask

    task automatic test_rf_en_rules();
        int         t_s    [3] = '{2, 1, 0};
        logic [4:0] t_rd   [3] = '{5'd0, 5'd7, 5'd9};
        logic       t_en   [3] = '{1'b1, 1'b0, 1'b1};
        logic       t_wben [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] ep;
        for (int t = 0; t < 3; t++) begin
            drive(t_s[t], 1'b1, t_rd[t], $urandom, t_en[t]);
            advance();
            idle();
            advance();
            ep = '0;
            if (t_wben[t]) ep[t_rd[t]] = 1'b1;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (o_pend[m] !== ep) begin
                    n_err++;
                    $display("FAIL rf_pend case%0d dut%0d: got %h, want %h", t, m, o_pend[m], ep);
                end
                n_cmp++;
                if (wb_valid[m] !== 1'b1 || wb_rf_en[m] !== t_wben[t] || wb_rd[m] !== t_rd[t] ||
                    wb_src[m] !== 2'(t_s[t])) begin
                    n_err++;
                    $display("FAIL rf_retire case%0d dut%0d: got v=%b en=%b rd=%0d src=%0d, want 1/%b/%0d/%0d",
                             t, m, wb_valid[m], wb_rf_en[m], wb_rd[m], wb_src[m], t_wben[t], t_rd[t], t_s[t]);
                end
            end
        end
        advance();
    endtask

    task automatic test_flush();
        for (int s = 0; s < N; s++) drive(s, 1'b1, 5'(20 + s), $urandom, 1'b1);
        advance();
        src_valid[2] = 1'b0;
        advance();
        for (int s = 0; s < N; s++) drive(s, 1'b1, 5'(25 + s), $urandom, 1'b1);
        flush = 1'b1;
        advance();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_ready[m] !== 3'b000 || wb_valid[m] !== 1'b0) begin
                n_err++;
                $display("FAIL flush_cycle dut%0d: got ready=%b v=%b, want 000/0", m, o_ready[m], wb_valid[m]);
            end
        end
        idle();
        advance();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_pend[m] !== 32'd0 || o_ready[m] !== 3'b111 || wb_valid[m] !== 1'b0) begin
                n_err++;
                $display("FAIL flush_after dut%0d: got pend=%h ready=%b v=%b, want 0/111/0",
                         m, o_pend[m], o_ready[m], wb_valid[m]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int s = 0; s < N; s++) begin
                drive(s, $urandom_range(0, 3) != 0, 5'($urandom), $urandom, $urandom_range(0, 3) != 0);
            end
            flush = ($urandom_range(0, 39) == 0);
            advance();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (o_ready[m] !== e_ready[m] || o_pend[m] !== e_pend[m]) begin
                    n_err++;
                    $display("FAIL rand_comb c%0d dut%0d: got ready=%b pend=%h, want %b/%h",
                             c, m, o_ready[m], o_pend[m], e_ready[m], e_pend[m]);
                end
                n_cmp++;
                if (wb_valid[m] !== e_valid[m] || wb_rf_en[m] !== e_rf_en[m]) begin
                    n_err++;
                    $display("FAIL rand_valid c%0d dut%0d: got v=%b en=%b, want %b/%b",
                             c, m, wb_valid[m], wb_rf_en[m], e_valid[m], e_rf_en[m]);
                end
                if (e_valid[m]) begin
                    n_cmp++;
                    if (wb_src[m] !== 2'(e_src[m]) || wb_rd[m] !== e_rd[m] || wb_data[m] !== e_data[m]) begin
                        n_err++;
                        $display("FAIL rand_payload c%0d dut%0d: got src=%0d rd=%0d data=%h, want %0d/%0d/%h",
                                 c, m, wb_src[m], wb_rd[m], wb_data[m], e_src[m], e_rd[m], e_data[m]);
                    end
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 6; c++) begin
            for (int s = 0; s < N; s++) drive(s, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
            advance();
        end
        #2 arst_n = 1'b0;
        idle();
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if ({wb_valid[m], wb_rf_en[m], wb_rd[m], wb_data[m], wb_src[m]} !== '0 || pend[m] !== 32'd0) begin
                n_err++;
                $display("FAIL midreset_now dut%0d: got v=%b en=%b rd=%0d data=%h src=%0d pend=%h, want 0",
                         m, wb_valid[m], wb_rf_en[m], wb_rd[m], wb_data[m], wb_src[m], pend[m]);
            end
        end
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            advance();
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (wb_valid[m] !== 1'b0 || o_pend[m] !== 32'd0 || o_ready[m] !== 3'b111) begin
                    n_err++;
                    $display("FAIL midreset_after c%0d dut%0d: got v=%b pend=%h ready=%b, want 0/0/111",
                             c, m, wb_valid[m], o_pend[m], o_ready[m]);
                end
            end
        end
    endtask

    initial begin
        arst_n    = 1'b0;
        src_rd    = '0;
        src_data  = '0;
        src_rf_en = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rr_order();
        test_fixed_starve();
        test_rf_en_rules();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
